// File: rtl/axis_image_pipe_ctrl_pkg.sv
// Shared configuration for the image-pipe packet sequencer.
// Holds the header field layout, config beat counts, derived widths and
// the sequencer state encoding. Every file of the block imports this package.
package axis_image_pipe_ctrl_pkg;

  localparam int unsigned WORD_WIDTH         = 8;
  localparam int unsigned KERNEL_H_MAX       = 3;
  localparam int unsigned BEATS_CONFIG_3X3_1 = 20;
  localparam int unsigned BEATS_CONFIG_1X1_1 = 12;
  localparam int unsigned BITS_OTHER         = 8;
  localparam int unsigned I_IM_IN_IS_MAXPOOL = 0;
  localparam int unsigned I_IM_IN_KERNEL_H_1 = I_IM_IN_IS_MAXPOOL + BITS_OTHER;

  localparam int unsigned BITS_KERNEL_H_MAX  = $clog2(KERNEL_H_MAX);
  localparam int unsigned BITS_CONFIG_COUNT  = $clog2(BEATS_CONFIG_3X3_1 + 1);
  localparam int unsigned HDR_W              = I_IM_IN_KERNEL_H_1 + BITS_KERNEL_H_MAX;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_PIX  = 2'd2
  } state_e;

endpackage

// File: rtl/axis_image_pipe_ctrl_if.sv
// Handshake bundle around the image-pipe sequencer.
//   s_1_*   : stream-1 slave side (valid/last/header bits in, ready out)
//   s_2_*   : stream-2 slave side (valid/last in, ready out)
//   m_*     : downstream side (ready in; valid, cfg qualifier, tuser out)
// Modport slave is the sequencer's view; modport master is the environment's.
interface axis_image_pipe_ctrl_if;
  import axis_image_pipe_ctrl_pkg::*;

  logic                         s_1_tvalid;
  logic                         s_1_tlast;
  logic [HDR_W-1:0]             s_1_hdr;
  logic                         s_1_tready;
  logic                         s_2_tvalid;
  logic                         s_2_tlast;
  logic                         s_2_tready;
  logic                         m_tready;
  logic                         m_tvalid;
  logic                         m_is_cfg;
  logic [BITS_KERNEL_H_MAX-1:0] m_tuser;

  modport slave (
    input  s_1_tvalid, s_1_tlast, s_1_hdr, s_2_tvalid, s_2_tlast, m_tready,
    output s_1_tready, s_2_tready, m_tvalid, m_is_cfg, m_tuser
  );

  modport master (
    output s_1_tvalid, s_1_tlast, s_1_hdr, s_2_tvalid, s_2_tlast, m_tready,
    input  s_1_tready, s_2_tready, m_tvalid, m_is_cfg, m_tuser
  );

endinterface

// File: rtl/axis_image_pipe_ctrl.sv
// Packet sequencer in front of the two-stream image input pipe.
// Consumes the header beat, then passes config beats followed by pixel
// beats, joining stream 1 and (in maxpool/dual mode) stream 2 in lockstep.
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   bus           : axis_image_pipe_ctrl_if.slave (streams + downstream)
//   dual_mode     : latched maxpool flag, both streams active
//   err_last      : sticky tlast-mismatch error, cleared by reset only
// Optional (AXIS_IMAGE_PIPE_CTRL_STATS_EN defined):
//   pkt_count     : normal packet ends, wraps at 2^32
//   pix_beats     : pixel transfers of the current packet
module axis_image_pipe_ctrl
  import axis_image_pipe_ctrl_pkg::*;
(
  input  logic                   aclk,
  input  logic                   aresetn,
  axis_image_pipe_ctrl_if.slave  bus,
  output logic                   dual_mode,
  output logic                   err_last
`ifdef AXIS_IMAGE_PIPE_CTRL_STATS_EN
  ,
  output logic [31:0]            pkt_count,
  output logic [31:0]            pix_beats
`endif
);

  state_e                       state_q, state_d;
  logic [BITS_CONFIG_COUNT-1:0] cfg_cnt_q, cfg_cnt_d;
  logic [BITS_KERNEL_H_MAX-1:0] kernel_h_1_q, kernel_h_1_d;
  logic                         dual_mode_q, dual_mode_d;
  logic                         err_last_q, err_last_d;

  logic                         join_valid_c;
  logic                         xfer_c;
  logic                         last_mismatch_c;
  logic                         any_last_c;
  logic [BITS_KERNEL_H_MAX-1:0] hdr_kh_c;
  logic                         m_tvalid_c, s_1_tready_c, s_2_tready_c, m_is_cfg_c;
  logic                         unused_hdr_c;

  // Lockstep join: stream 2 only participates in dual mode.
  assign join_valid_c    = bus.s_1_tvalid & (~dual_mode_q | bus.s_2_tvalid);
  assign xfer_c          = join_valid_c & bus.m_tready;
  assign last_mismatch_c = dual_mode_q & (bus.s_1_tlast ^ bus.s_2_tlast);
  assign any_last_c      = bus.s_1_tlast | (dual_mode_q & bus.s_2_tlast);
  assign hdr_kh_c        = bus.s_1_hdr[I_IM_IN_KERNEL_H_1 +: BITS_KERNEL_H_MAX];
  // The "other" header bits are carried on the bus but not interpreted here.
  assign unused_hdr_c    = ^bus.s_1_hdr;

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      cfg_cnt_q    <= '0;
      kernel_h_1_q <= '0;
      dual_mode_q  <= 1'b0;
      err_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_cnt_q    <= cfg_cnt_d;
      kernel_h_1_q <= kernel_h_1_d;
      dual_mode_q  <= dual_mode_d;
      err_last_q   <= err_last_d;
    end
  end

  // Next-state and handshake gating.
  always_comb begin
    state_d      = state_q;
    cfg_cnt_d    = cfg_cnt_q;
    kernel_h_1_d = kernel_h_1_q;
    dual_mode_d  = dual_mode_q;
    err_last_d   = err_last_q;
    m_tvalid_c   = 1'b0;
    s_1_tready_c = 1'b0;
    s_2_tready_c = 1'b0;
    m_is_cfg_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Ready is held low while reset is asserted so every output reads 0.
        s_1_tready_c = aresetn;
        if (bus.s_1_tvalid) begin
          kernel_h_1_d = hdr_kh_c;
          dual_mode_d  = bus.s_1_hdr[I_IM_IN_IS_MAXPOOL];
          cfg_cnt_d    = (hdr_kh_c == '0) ? BITS_CONFIG_COUNT'(BEATS_CONFIG_1X1_1)
                                          : BITS_CONFIG_COUNT'(BEATS_CONFIG_3X3_1);
          if (bus.s_1_tlast) begin
            err_last_d = 1'b1;
          end else begin
            state_d = ST_CFG;
          end
        end
      end

      ST_CFG: begin
        m_tvalid_c   = join_valid_c;
        s_1_tready_c = xfer_c;
        s_2_tready_c = dual_mode_q & xfer_c;
        m_is_cfg_c   = 1'b1;
        if (xfer_c) begin
          if (any_last_c) begin
            err_last_d = 1'b1;
            state_d    = ST_IDLE;
          end else if (cfg_cnt_q == '0) begin
            state_d = ST_PIX;
          end else begin
            cfg_cnt_d = cfg_cnt_q - BITS_CONFIG_COUNT'(1);
          end
        end
      end

      ST_PIX: begin
        m_tvalid_c   = join_valid_c;
        s_1_tready_c = xfer_c;
        s_2_tready_c = dual_mode_q & xfer_c;
        if (xfer_c) begin
          if (last_mismatch_c) begin
            err_last_d = 1'b1;
            state_d    = ST_IDLE;
          end else if (bus.s_1_tlast) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.m_tvalid   = m_tvalid_c;
  assign bus.s_1_tready = s_1_tready_c;
  assign bus.s_2_tready = s_2_tready_c;
  assign bus.m_is_cfg   = m_is_cfg_c;
  assign bus.m_tuser    = kernel_h_1_q;
  assign dual_mode      = dual_mode_q;
  assign err_last       = err_last_q;

`ifdef AXIS_IMAGE_PIPE_CTRL_STATS_EN
  logic        hdr_acc_c, pix_xfer_c, pkt_end_c;
  logic [31:0] pkt_count_q, pkt_count_d;
  logic [31:0] pix_beats_q, pix_beats_d;

  assign hdr_acc_c  = (state_q == ST_IDLE) & bus.s_1_tvalid;
  assign pix_xfer_c = (state_q == ST_PIX) & xfer_c;
  assign pkt_end_c  = pix_xfer_c & bus.s_1_tlast & ~last_mismatch_c;

  // Packet and pixel-beat counters; pix_beats restarts at each header.
  always_comb begin
    pkt_count_d = pkt_count_q + 32'(pkt_end_c);
    pix_beats_d = hdr_acc_c ? 32'd0 : pix_beats_q + 32'(pix_xfer_c);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_count_q <= '0;
      pix_beats_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_d;
      pix_beats_q <= pix_beats_d;
    end
  end

  assign pkt_count = pkt_count_q;
  assign pix_beats = pix_beats_q;
`endif

endmodule

// File: tb/tb_axis_image_pipe_ctrl.sv
// Self-checking bench for axis_image_pipe_ctrl: packet vectors from a table
// plus hand-driven stall, tlast-mismatch, mid-packet reset and back-to-back
// sequences. Beat expectations are queued when a beat is presented and
// popped when the DUT reports a downstream transfer.
module tb_axis_image_pipe_ctrl;
  import axis_image_pipe_ctrl_pkg::*;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic dual_mode, err_last;
`ifdef AXIS_IMAGE_PIPE_CTRL_STATS_EN
  logic [31:0] pkt_count, pix_beats;
  int exp_pkt = 0;
`endif

  axis_image_pipe_ctrl_if bus();

  axis_image_pipe_ctrl dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .bus       (bus),
    .dual_mode (dual_mode),
    .err_last  (err_last)
`ifdef AXIS_IMAGE_PIPE_CTRL_STATS_EN
    ,
    .pkt_count (pkt_count),
    .pix_beats (pix_beats)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic                         is_cfg;
    logic [BITS_KERNEL_H_MAX-1:0] tuser;
  } exp_t;

  typedef struct {
    logic [BITS_KERNEL_H_MAX-1:0] kh;
    logic                         mp;
    int                           npix;
    logic                         rnd;
    int                           stall_beat;
    int                           exp_ncfg;
    logic [BITS_KERNEL_H_MAX-1:0] exp_tuser;
    logic                         exp_dual;
  } vec_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   obs_cfg = 0;
  bit   m_data = 1'b0;
  bit   m_dual = 1'b0;
  bit   m_in_cfg = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.s_1_tvalid = 1'b0;
    bus.s_1_tlast  = 1'b0;
    bus.s_1_hdr    = '0;
    bus.s_2_tvalid = 1'b0;
    bus.s_2_tlast  = 1'b0;
    bus.m_tready   = 1'b1;
  endtask

  // One clock: check gating against the model, score any transfer, advance.
  task automatic step(output bit mx);
    logic ev, e1, e2, ec;
    exp_t e;
    #2;
    ev = m_data & bus.s_1_tvalid & (~m_dual | bus.s_2_tvalid);
    e1 = m_data ? (ev & bus.m_tready) : 1'b1;
    e2 = m_data & m_dual & ev & bus.m_tready;
    ec = m_data & m_in_cfg;
    check("handshake", 64'({bus.m_tvalid, bus.s_1_tready, bus.s_2_tready, bus.m_is_cfg}),
          64'({ev, e1, e2, ec}));
    if (bus.m_tvalid && bus.m_tready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL xfer: got an unexpected transfer, expected none (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("beat", 64'({bus.m_is_cfg, bus.m_tuser}), 64'({e.is_cfg, e.tuser}));
        if (bus.m_is_cfg) obs_cfg++;
      end
    end
    mx = m_data ? (ev & bus.m_tready) : bus.s_1_tvalid;
    @(posedge aclk);
    #1;
  endtask

  // Header, ncfg config beats, npix pixel beats (tlast on the final one).
  task automatic send_pkt(input logic [BITS_KERNEL_H_MAX-1:0] kh, input logic mp,
                          input int ncfg, input int npix, input logic rnd,
                          input int stall_beat, input logic mismatch, input int stop_after);
    logic [HDR_W-1:0] h;
    bit   mx, pushed, last;
    int   b, total, budget, stall;
    h = '0;
    h[I_IM_IN_KERNEL_H_1 +: BITS_KERNEL_H_MAX] = kh;
    h[I_IM_IN_IS_MAXPOOL] = mp;
    bus.s_1_tvalid = 1'b1;
    bus.s_1_tlast  = 1'b0;
    bus.s_1_hdr    = h;
    bus.s_2_tvalid = 1'b0;
    bus.s_2_tlast  = 1'b0;
    bus.m_tready   = 1'b1;
    obs_cfg = 0;
    step(mx);
    m_data   = 1'b1;
    m_dual   = mp;
    m_in_cfg = (ncfg > 0);
    total    = ncfg + npix;
    b = 0; budget = 0; stall = 0; pushed = 1'b0;
    while (b < total && b < stop_after) begin
      if (!pushed) begin
        exp_q.push_back('{is_cfg: (b < ncfg), tuser: kh});
        pushed = 1'b1;
      end
      last = (b == total - 1);
      bus.s_1_tvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.s_2_tvalid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.m_tready   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (b == stall_beat && stall < 5) begin
        bus.s_1_tvalid = 1'b1;
        bus.s_2_tvalid = 1'b1;
        bus.m_tready   = 1'b0;
        stall++;
      end
      bus.s_1_tlast = last;
      bus.s_2_tlast = last & ~mismatch;
      bus.s_1_hdr   = HDR_W'($urandom);
      step(mx);
      if (mx) begin
        b++;
        m_in_cfg = (b < ncfg);
        pushed   = 1'b0;
      end
      budget++;
      if (budget > 3000) begin
        tests++;
        fails++;
        $display("FAIL timeout: packet stuck at beat %0d, expected %0d beats", b, total);
        break;
      end
    end
    if (b == total) m_data = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    bit mx;
    vecs[0] = '{2'd1, 1'b0, 50, 1'b0, -1, 21, 2'd1, 1'b0};
    vecs[1] = '{2'd0, 1'b1,  8, 1'b1, -1, 13, 2'd0, 1'b1};
    vecs[2] = '{2'd1, 1'b0,  6, 1'b0, 13, 21, 2'd1, 1'b0};
    vecs[3] = '{2'd2, 1'b1,  5, 1'b1, -1, 21, 2'd2, 1'b1};
    vecs[4] = '{2'd0, 1'b0,  1, 1'b0, -1, 13, 2'd0, 1'b0};

    idle_inputs();
    aresetn = 1'b0;
    #3;
    check("reset_outs", 64'({bus.m_tvalid, bus.s_1_tready, bus.s_2_tready, bus.m_is_cfg,
                             bus.m_tuser, dual_mode, err_last}), 64'(0));
`ifdef AXIS_IMAGE_PIPE_CTRL_STATS_EN
    check("reset_stats", 64'({pkt_count, pix_beats}), 64'(0));
`endif
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Back-to-back packets from the table.
    for (int i = 0; i < 5; i++) begin
      send_pkt(vecs[i].kh, vecs[i].mp, vecs[i].exp_ncfg, vecs[i].npix, vecs[i].rnd,
               vecs[i].stall_beat, 1'b0, 1 << 20);
      check("ncfg", 64'(obs_cfg), 64'(vecs[i].exp_ncfg));
      check("tuser", 64'(bus.m_tuser), 64'(vecs[i].exp_tuser));
      check("dual", 64'(dual_mode), 64'(vecs[i].exp_dual));
      check("err_clear", 64'(err_last), 64'(0));
      check("sb_empty", 64'(exp_q.size()), 64'(0));
`ifdef AXIS_IMAGE_PIPE_CTRL_STATS_EN
      exp_pkt++;
      check("pkt_count", 64'(pkt_count), 64'(exp_pkt));
      check("pix_beats", 64'(pix_beats), 64'(vecs[i].npix));
`endif
    end
    idle_inputs();

    // Dual mode, pixel beat 10 ends with s_1_tlast=1, s_2_tlast=0.
    send_pkt(2'd0, 1'b1, 13, 10, 1'b0, -1, 1'b1, 1 << 20);
    idle_inputs();
    check("err_mismatch", 64'(err_last), 64'(1));
    step(mx);
`ifdef AXIS_IMAGE_PIPE_CTRL_STATS_EN
    check("pkt_no_inc", 64'(pkt_count), 64'(exp_pkt));
    check("pix_err_beats", 64'(pix_beats), 64'(10));
`endif
    check("err_sticky", 64'(err_last), 64'(1));

    // Reset in the middle of the pixel phase.
    send_pkt(2'd2, 1'b1, 21, 30, 1'b0, -1, 1'b0, 27);
    bus.s_1_tvalid = 1'b1;
    bus.s_2_tvalid = 1'b1;
    bus.m_tready   = 1'b1;
    #2;
    aresetn = 1'b0;
    #1;
    check("rst_async", 64'({bus.m_tvalid, bus.s_1_tready, bus.s_2_tready, bus.m_is_cfg,
                            bus.m_tuser, dual_mode, err_last}), 64'(0));
`ifdef AXIS_IMAGE_PIPE_CTRL_STATS_EN
    check("rst_stats", 64'({pkt_count, pix_beats}), 64'(0));
    exp_pkt = 0;
`endif
    exp_q.delete();
    m_data = 1'b0;
    m_in_cfg = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    idle_inputs();

    // Two packets back to back after reset.
    send_pkt(2'd1, 1'b0, 21, 4, 1'b0, -1, 1'b0, 1 << 20);
    check("post_rst_tuser", 64'({bus.m_tuser, dual_mode, err_last}), 64'({2'd1, 1'b0, 1'b0}));
    send_pkt(2'd0, 1'b1, 13, 3, 1'b1, -1, 1'b0, 1 << 20);
    idle_inputs();
    check("b2b_status", 64'({bus.m_tuser, dual_mode, err_last}), 64'({2'd0, 1'b1, 1'b0}));
    check("b2b_sb_empty", 64'(exp_q.size()), 64'(0));
`ifdef AXIS_IMAGE_PIPE_CTRL_STATS_EN
    check("b2b_pkt_count", 64'(pkt_count), 64'(2));
`endif
    step(mx);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
